// File: rtl/fsm_sched_if.sv
// fsm_sched_if: request/grant, job-result and detector-link signals of the scheduler
//   req       requester level requests (bit i = requester i)
//   data_in   packed words, slice [i*WIDTH +: WIDTH] belongs to requester i
//   gnt       one-hot grant held for the whole job
//   det_rst   active-high reset to the shared sequence detector
//   det_in    serial bit to the detector
//   det_out   detector output
//   done      one-cycle job-complete pulse
//   done_id   requester just served
//   done_hits number of counted det_out=1 samples in that job
interface fsm_sched_if #(parameter int WIDTH = 8);
    localparam int HW = $clog2(WIDTH + 1);
    logic [3:0]         req;
    logic [4*WIDTH-1:0] data_in;
    logic [3:0]         gnt;
    logic               det_rst;
    logic               det_in;
    logic               det_out;
    logic               done;
    logic [1:0]         done_id;
    logic [HW-1:0]      done_hits;
    modport master (output req, data_in, det_out, input gnt, det_rst, det_in, done, done_id, done_hits);
    modport slave  (input req, data_in, det_out, output gnt, det_rst, det_in, done, done_id, done_hits);
endinterface

// File: rtl/fsm_sched.sv
// fsm_sched: round-robin scheduler that serializes a granted requester's word into a shared sequence detector and counts its hits
//   clock  rising-edge clock
//   reset  asynchronous active-low reset
//   bus    fsm_sched_if slave: req/data_in in, gnt out, detector link, done/done_id/done_hits out
module fsm_sched #(
    parameter int WIDTH = 8
) (
    input logic        clock,
    input logic        reset,
    fsm_sched_if.slave bus
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int HW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, DONE} state_t;

    state_t         state, state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [IW-1:0]  idx;
    logic [HW-1:0]  hits, hits_nxt;
    logic [1:0]     rr, win, id;
    logic           inc;

    // lowest offset from rr wins, so scan offsets from high to low
    always_comb begin
        win = rr;
        for (int k = 3; k >= 0; k--)
            if (bus.req[rr + 2'(k)]) win = rr + 2'(k);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = |bus.req ? CLR : IDLE;
            CLR:     state_nxt = SHIFT;
            SHIFT:   state_nxt = (idx == IW'(WIDTH - 1)) ? DRAIN : SHIFT;
            DRAIN:   state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // the first shift cycle still sees the detector's post-reset output, so it is not counted
    assign inc      = bus.det_out && ((state == SHIFT && idx != '0) || state == DRAIN);
    assign hits_nxt = (state == CLR) ? '0 :
                      (inc && hits != HW'(WIDTH)) ? hits + HW'(1) : hits;

    assign bus.det_in = (state == SHIFT) && sreg[WIDTH-1];
    assign bus.done   = (state == DONE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            bus.gnt       <= '0;
            bus.det_rst   <= 1'b1;
            bus.done_id   <= '0;
            bus.done_hits <= '0;
            rr            <= '0;
            id            <= '0;
            sreg          <= '0;
            idx           <= '0;
            hits          <= '0;
        end else begin
            state       <= state_nxt;
            bus.det_rst <= (state_nxt == CLR);
            hits        <= hits_nxt;
            if (state == IDLE && |bus.req) begin
                sreg    <= bus.data_in[int'(win)*WIDTH +: WIDTH];
                bus.gnt <= 4'b0001 << win;
                id      <= win;
            end
            if (state == CLR) idx <= '0;
            if (state == SHIFT) begin
                sreg <= sreg << 1;
                idx  <= idx + IW'(1);
            end
            // results are loaded as DONE is entered so they are valid alongside the done pulse
            if (state == DRAIN) begin
                bus.done_id   <= id;
                bus.done_hits <= hits_nxt;
            end
            if (state == DONE) begin
                bus.gnt <= '0;
                rr      <= id + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_fsm_sched.sv
// tb_fsm_sched: directed self-checking bench for fsm_sched with a "11" Moore sequence-detector model
module tb_fsm_sched;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic stuck = 1'b0;
    logic [1:0] ds;
    int vec = 0;
    int errs = 0;

    fsm_sched_if #(.WIDTH(8)) dut_if ();
    fsm_sched #(.WIDTH(8)) dut (.clock(clock), .reset(reset), .bus(dut_if));

    always #5 clock = ~clock;

    always_ff @(posedge clock)
        ds <= dut_if.det_rst ? 2'd0 : dut_if.det_in ? ((ds == 2'd0) ? 2'd1 : 2'd2) : 2'd0;
    assign dut_if.det_out = stuck | (ds == 2'd2);

    function automatic int golden(input logic [7:0] w);
        int s = 0;
        int h = 0;
        for (int k = 7; k >= 0; k--) begin
            s = w[k] ? ((s == 0) ? 1 : 2) : 0;
            if (s == 2) h++;
        end
        return h;
    endfunction

    task automatic wait_done(output int c, output logic [7:0] s, output logic [3:0] g);
        c = 0; s = '0; g = '0;
        do begin
            @(negedge clock);
            c++;
            if (c == 1) g = dut_if.gnt;
            if (c >= 2 && c <= 9) s[9-c] = dut_if.det_in;
        end while (!dut_if.done && c < 40);
    endtask

    task automatic test_reset();
        dut_if.req = '0; dut_if.data_in = '0;
        repeat (2) @(negedge clock);
        vec++; if (dut_if.gnt !== 4'b0) begin errs++; $display("FAIL reset_gnt got %b want 0000", dut_if.gnt); end
        vec++; if (dut_if.det_rst !== 1'b1) begin errs++; $display("FAIL reset_det_rst got %b want 1", dut_if.det_rst); end
        vec++; if (dut_if.det_in !== 1'b0) begin errs++; $display("FAIL reset_det_in got %b want 0", dut_if.det_in); end
        vec++; if (dut_if.done !== 1'b0) begin errs++; $display("FAIL reset_done got %b want 0", dut_if.done); end
        vec++; if (dut_if.done_id !== 2'd0) begin errs++; $display("FAIL reset_done_id got %0d want 0", dut_if.done_id); end
        vec++; if (dut_if.done_hits !== 4'd0) begin errs++; $display("FAIL reset_done_hits got %0d want 0", dut_if.done_hits); end
        reset = 1'b1;
        @(negedge clock);
        vec++; if (dut_if.det_rst !== 1'b0) begin errs++; $display("FAIL release_det_rst got %b want 0", dut_if.det_rst); end
    endtask

    task automatic test_single();
        int c; logic [7:0] s; logic [3:0] g;
        dut_if.data_in[7:0] = 8'b1011_0110;
        dut_if.req = 4'b0001;
        @(posedge clock); #1 dut_if.req = '0;
        @(negedge clock);
        vec++; if (dut_if.det_rst !== 1'b1) begin errs++; $display("FAIL clr_det_rst got %b want 1", dut_if.det_rst); end
        c = 1; s = '0; g = dut_if.gnt;
        do begin
            @(negedge clock); c++;
            if (c == 2) begin vec++; if (dut_if.det_rst !== 1'b0) begin errs++; $display("FAIL shift_det_rst got %b want 0", dut_if.det_rst); end end
            if (c >= 2 && c <= 9) s[9-c] = dut_if.det_in;
            if (c == 10) begin vec++; if (dut_if.det_in !== 1'b0) begin errs++; $display("FAIL drain_det_in got %b want 0", dut_if.det_in); end end
        end while (!dut_if.done && c < 40);
        vec++; if (g !== 4'b0001) begin errs++; $display("FAIL single_gnt got %b want 0001", g); end
        vec++; if (s !== 8'b1011_0110) begin errs++; $display("FAIL single_stream got %b want 10110110", s); end
        vec++; if (c !== 11) begin errs++; $display("FAIL single_latency got %0d want 11", c); end
        vec++; if (dut_if.done_id !== 2'd0) begin errs++; $display("FAIL single_id got %0d want 0", dut_if.done_id); end
        vec++; if (int'(dut_if.done_hits) !== golden(8'b1011_0110)) begin errs++; $display("FAIL single_hits got %0d want %0d", dut_if.done_hits, golden(8'b1011_0110)); end
        @(negedge clock);
        vec++; if (dut_if.done !== 1'b0 || dut_if.gnt !== 4'b0) begin errs++; $display("FAIL single_pulse done=%b gnt=%b want 0/0000", dut_if.done, dut_if.gnt); end
        vec++; if (dut_if.done_id !== 2'd0 || int'(dut_if.done_hits) !== golden(8'b1011_0110)) begin errs++; $display("FAIL single_hold id=%0d hits=%0d", dut_if.done_id, dut_if.done_hits); end
    endtask

    task automatic test_round_robin();
        int c; logic [7:0] s; logic [3:0] g; logic [1:0] e;
        logic [31:0] d;
        d = {8'hFF, 8'h33, 8'hE7, 8'hB6};
        dut_if.data_in = d;
        dut_if.req = 4'b1111;
        @(posedge clock);
        for (int j = 0; j < 5; j++) begin
            if (j > 0) begin @(posedge clock); @(posedge clock); end
            wait_done(c, s, g);
            e = 2'(1 + j);
            vec++; if (g !== (4'b0001 << e)) begin errs++; $display("FAIL rr_gnt job%0d got %b want %b", j, g, 4'b0001 << e); end
            vec++; if (c !== 11 || dut_if.done_id !== e) begin errs++; $display("FAIL rr_done job%0d lat=%0d id=%0d want 11/%0d", j, c, dut_if.done_id, e); end
            vec++; if (s !== d[int'(e)*8 +: 8] || int'(dut_if.done_hits) !== golden(d[int'(e)*8 +: 8])) begin errs++; $display("FAIL rr_data job%0d stream=%h hits=%0d want %h/%0d", j, s, dut_if.done_hits, d[int'(e)*8 +: 8], golden(d[int'(e)*8 +: 8])); end
        end
        dut_if.req = '0;
        @(negedge clock);
    endtask

    task automatic test_capture();
        int c; logic [7:0] s; logic [3:0] g;
        dut_if.data_in[23:16] = 8'b1110_0111;
        dut_if.req = 4'b0100;
        @(posedge clock);
        fork
            wait_done(c, s, g);
            begin repeat (4) @(posedge clock); #1 dut_if.req = 4'b0001; dut_if.data_in[23:16] = 8'h00; end
        join
        vec++; if (g !== 4'b0100 || dut_if.done_id !== 2'd2) begin errs++; $display("FAIL cap_gnt gnt=%b id=%0d want 0100/2", g, dut_if.done_id); end
        vec++; if (s !== 8'b1110_0111) begin errs++; $display("FAIL cap_stream got %b want 11100111", s); end
        vec++; if (int'(dut_if.done_hits) !== golden(8'b1110_0111)) begin errs++; $display("FAIL cap_hits got %0d want %0d", dut_if.done_hits, golden(8'b1110_0111)); end
        @(posedge clock); @(posedge clock);
        wait_done(c, s, g);
        dut_if.req = '0;
        vec++; if (g !== 4'b0001 || dut_if.done_id !== 2'd0 || c !== 11) begin errs++; $display("FAIL wait_job gnt=%b id=%0d lat=%0d want 0001/0/11", g, dut_if.done_id, c); end
        @(negedge clock);
    endtask

    task automatic test_mid_reset();
        int c; logic [7:0] s; logic [3:0] g; bit saw;
        dut_if.data_in = {8'h00, 8'h00, 8'hFF, 8'hFF};
        dut_if.req = 4'b0010;
        @(posedge clock); #1 dut_if.req = '0;
        repeat (6) @(negedge clock);
        vec++; if (dut_if.gnt !== 4'b0010) begin errs++; $display("FAIL mid_gnt got %b want 0010", dut_if.gnt); end
        #2 reset = 1'b0;
        #1;
        vec++; if (dut_if.gnt !== 4'b0 || dut_if.det_rst !== 1'b1 || dut_if.det_in !== 1'b0) begin errs++; $display("FAIL async_rst gnt=%b det_rst=%b det_in=%b want 0000/1/0", dut_if.gnt, dut_if.det_rst, dut_if.det_in); end
        vec++; if (dut_if.done !== 1'b0 || dut_if.done_id !== 2'd0 || dut_if.done_hits !== 4'd0) begin errs++; $display("FAIL async_res done=%b id=%0d hits=%0d want 0/0/0", dut_if.done, dut_if.done_id, dut_if.done_hits); end
        saw = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            if (i == 2) reset = 1'b1;
            if (dut_if.done) saw = 1;
        end
        vec++; if (saw !== 1'b0) begin errs++; $display("FAIL abandon_done got 1 want 0"); end
        dut_if.req = 4'b0011;
        @(posedge clock); #1 dut_if.req = '0;
        wait_done(c, s, g);
        vec++; if (g !== 4'b0001 || dut_if.done_id !== 2'd0 || s !== 8'hFF) begin errs++; $display("FAIL post_rst gnt=%b id=%0d stream=%h want 0001/0/ff", g, dut_if.done_id, s); end
        @(negedge clock);
    endtask

    task automatic test_stuck();
        int c; logic [7:0] s; logic [3:0] g;
        stuck = 1'b1;
        dut_if.data_in[23:16] = 8'h00;
        dut_if.req = 4'b0100;
        @(posedge clock); #1 dut_if.req = '0;
        wait_done(c, s, g);
        vec++; if (g !== 4'b0100) begin errs++; $display("FAIL stuck_gnt got %b want 0100", g); end
        vec++; if (dut_if.done_hits !== 4'd8) begin errs++; $display("FAIL stuck_hits got %0d want 8", dut_if.done_hits); end
        stuck = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_capture();
        test_mid_reset();
        test_stuck();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
